riscv_id: RTL and testbench
===========================

// Module: riscv_id
// PURPOSE
//  Decode/operand-fetch stage directly upstream of the RV32I execute stage. Owns the 32-entry integer
//  register file, decodes OP, OP-IMM and LUI instructions and presents registered operands
//  (rdi, a, b, shamt, funct3, invertb) to the execute stage one cycle after acceptance.
//  Resolves data hazards by forwarding from execute/writeback and by a one-cycle stall.
// PARAMETERS
//  XLEN        32  datapath width; only 32 supported
//  RESET_REGS  1   1: synchronous reset also clears x1..x31; 0: register file not reset
// PORTS
//  rst        in   1     synchronous active-high reset
//  clk        in   1     rising-edge clock
//  instr      in   32    instruction word from fetch
//  instr_valid in  1     instr holds a valid instruction this cycle
//  instr_ready out 1     combinational; instr accepted at this edge when instr_valid & instr_ready
//  ex_rd      in   5     execute stage registered rd (result register of instruction issued 2 cycles ago)
//  ex_result  in   32    execute stage registered result
//  wb_en      in   1     writeback write enable
//  wb_rd      in   5     writeback destination
//  wb_data    in   32    writeback data
//  rdi        out  5     destination register for execute (0 = bubble/no write)
//  a          out  32    operand A
//  b          out  32    operand B (immediate or rs2 value)
//  shamt      out  6     shift amount, {1'b0, amount[4:0]}; 0 for non-shifts
//  funct3     out  3     ALU operation, RISC-V funct3 encoding
//  invertb    out  1     SUB / SRA / SRAI select
//  valid      out  1     outputs carry a real instruction this cycle
//  illegal    out  1     one-cycle pulse: accepted word had an unsupported opcode/encoding
// BEHAVIOUR
//  - Reset: rdi=0, a=0, b=0, shamt=0, funct3=0, invertb=0, valid=0, illegal=0, last_rd=0; regs cleared if RESET_REGS.
//    Reset wins over every other event in the same cycle, including a pending stall and a wb write.
//  - Latency 1: instruction accepted at edge N appears on outputs after edge N, held for exactly one cycle.
//  - Bubble (no accept, stall or illegal): rdi=0, a=b=0, shamt=0, funct3=0, invertb=0, valid=0.
//  - Decode (opcode = instr[6:0]):
//    0110011 OP: a=rs1, b=rs2, funct3=instr[14:12]; invertb=instr[30] for funct3 000 (SUB) and 101 (SRA),
//      else instr[30] must be 0; shifts: shamt={1'b0,rs2[4:0]}.
//    0010011 OP-IMM: a=rs1, b=sign-extended instr[31:20]; shifts (001,101): shamt={1'b0,instr[24:20]},
//      invertb=instr[30] for 101 (SRAI); instr[31:25] other than 0000000/0100000 -> illegal.
//    0110111 LUI: a=0, b={instr[31:12],12'b0}, funct3=000, invertb=0.
//    Anything else, or bad funct7 -> illegal=1 for one cycle, bubble issued, word consumed.
//  - SUB contract: b is raw rs2; execute forms a + ~b + 1 when invertb=1 and funct3=000.
//  - Register file: x0 reads 0; writes to x0 ignored; wb write at edge occurs regardless of stall.
//  - Operand source priority per rs (rs!=0): ex_rd==rs -> ex_result; else wb_en & wb_rd==rs -> wb_data;
//    else register file. rs==0 always yields 0.
//  - Hazard: last_rd = rdi issued at previous edge (0 for bubble). If instr_valid and a used rs
//    (rs1 for OP/OP-IMM, rs2 for OP) equals last_rd != 0 -> instr_ready=0, bubble issued, last_rd
//    becomes 0; next cycle the same instr is accepted with the value forwarded via ex_rd.
//  - instr_ready=1 whenever no hazard, including when instr_valid=0; LUI never stalls.
//  - Back-to-back independent instructions issue every cycle, no bubbles.
// TESTING
//  1. Reset, then idle 3 cycles -> all outputs 0, valid=0, instr_ready=1, illegal=0.
//  2. wb x1=40, x2=2 (wb_en), then ADD x4,x1,x2 -> next cycle rdi=4, a=40, b=2, funct3=000, invertb=0, valid=1.
//  3. ADDI x5,x0,-5 -> b=32'hFFFFFFFB, a=0; SRAI x6,x1,3 -> funct3=101, shamt=3, invertb=1.
//  4. ADD x4,.. then SUB x7,x4,x2 back-to-back -> instr_ready=0 one cycle, bubble (valid=0, rdi=0),
//     then with ex_rd=4, ex_result=42: rdi=7, a=42, b=2, invertb=1.
//  5. Opcode 7'b1111111 -> illegal=1 one cycle, bubble, next instr accepted; write x0 then read -> a=0.
//  6. Assert rst during a stall cycle -> next cycle all outputs 0, instr_ready=1, regs cleared.

Source files
------------

// File: rtl/riscv_id.sv
// riscv_id: RV32I decode/operand-fetch stage with register file, forwarding and one-cycle hazard stall.
//   Inputs : clk, rst, instr/instr_valid from fetch, ex_rd/ex_result forward path, wb_en/wb_rd/wb_data writeback
//   Outputs: instr_ready (combinational), registered rdi/a/b/shamt/funct3/invertb/valid/illegal to execute
module riscv_id #(
   parameter int XLEN       = 32,
   parameter bit RESET_REGS = 1'b1
) (
   input  logic            rst,
   input  logic            clk,
   input  logic [31:0]     instr,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_result,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [4:0]      rdi,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output logic [5:0]      shamt,
   output logic [2:0]      funct3,
   output logic            invertb,
   output logic            valid,
   output logic            illegal
);
   logic [XLEN-1:0] regs [0:31];
   logic [6:0] opc, f7;
   logic [4:0] rs1, rs2, rd;
   logic [2:0] f3;
   logic is_op, is_opi, is_lui, is_shift, f7_ok, legal, haz, accept;
   logic [XLEN-1:0] rs1v, rs2v, imm;
   logic [4:0] n_rdi;
   logic [XLEN-1:0] n_a, n_b;
   logic [5:0] n_sh;
   logic [2:0] n_f3;
   logic n_inv, n_val, n_ill;
   assign opc      = instr[6:0];
   assign rd       = instr[11:7];
   assign f3       = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign f7       = instr[31:25];
   assign is_op    = opc == 7'b0110011;
   assign is_opi   = opc == 7'b0010011;
   assign is_lui   = opc == 7'b0110111;
   assign is_shift = f3[1:0] == 2'b01;
   // 0100000 is only meaningful for SUB/SRA in OP; OP-IMM shifts accept either funct7 form
   assign f7_ok    = f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (!is_op || f3 == 3'b000 || f3 == 3'b101));
   assign legal    = is_lui || (is_op && f7_ok) || (is_opi && (!is_shift || f7_ok));
   // rdi is the destination issued at the previous edge, i.e. the producer not yet visible on ex_rd
   assign haz      = instr_valid && rdi != 5'd0 &&
                     (((is_op || is_opi) && rs1 == rdi) || (is_op && rs2 == rdi));
   assign instr_ready = !haz;
   assign accept   = instr_valid && !haz;
   assign rs1v = rs1 == 5'd0 ? '0 : ex_rd == rs1 ? ex_result :
                 (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
   assign rs2v = rs2 == 5'd0 ? '0 : ex_rd == rs2 ? ex_result :
                 (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
   assign imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   always_comb begin
      n_rdi = '0;
      n_a   = '0;
      n_b   = '0;
      n_sh  = '0;
      n_f3  = '0;
      n_inv = 1'b0;
      n_val = 1'b0;
      n_ill = accept && !legal;
      if (accept && legal) begin
         n_val = 1'b1;
         n_rdi = rd;
         n_f3  = is_lui ? 3'b000 : f3;
         n_a   = is_lui ? '0 : rs1v;
         n_b   = is_op ? rs2v : is_opi ? imm : {instr[31:12], {(XLEN-20){1'b0}}};
         n_inv = instr[30] && ((is_op && (f3 == 3'b000 || f3 == 3'b101)) || (is_opi && f3 == 3'b101));
         n_sh  = (!is_lui && is_shift) ? {1'b0, is_op ? rs2v[4:0] : rs2} : 6'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rdi     <= '0;
         a       <= '0;
         b       <= '0;
         shamt   <= '0;
         funct3  <= '0;
         invertb <= 1'b0;
         valid   <= 1'b0;
         illegal <= 1'b0;
      end else begin
         rdi     <= n_rdi;
         a       <= n_a;
         b       <= n_b;
         shamt   <= n_sh;
         funct3  <= n_f3;
         invertb <= n_inv;
         valid   <= n_val;
         illegal <= n_ill;
      end
   end
   // Writeback is independent of stalls; reset suppresses it
   always_ff @(posedge clk) begin
      if (rst) begin
         if (RESET_REGS)
            for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_en && wb_rd != 5'd0)
         regs[wb_rd] <= wb_data;
   end
endmodule

// File: tb/tb_riscv_id.sv
// tb_riscv_id: table-driven directed bench for riscv_id plus hazard and reset sequences.
module tb_riscv_id;
   logic rst, clk, instr_valid, instr_ready, wb_en, invertb, valid, illegal;
   logic [31:0] instr, ex_result, wb_data, a, b;
   logic [4:0] ex_rd, wb_rd, rdi;
   logic [5:0] shamt;
   logic [2:0] funct3;
   int total = 0, bad = 0;

   riscv_id dut (
      .rst(rst), .clk(clk), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .ex_rd(ex_rd), .ex_result(ex_result), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .rdi(rdi), .a(a), .b(b), .shamt(shamt), .funct3(funct3), .invertb(invertb),
      .valid(valid), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] instr;
      logic [4:0]  exrd;
      logic [31:0] exres;
      logic        wbe;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic        rdy;
      logic [4:0]  rdi;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  sh;
      logic [2:0]  f3;
      logic        inv;
      logic        val;
      logic        ill;
   } vec_t;

   vec_t tv [19];

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, s1,
                                         input logic [2:0] f, input logic [4:0] d);
      return {f7, s2, s1, f, d, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                         input logic [2:0] f, input logic [4:0] d);
      return {im, s1, f, d, 7'b0010011};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] d);
      return {im, d, 7'b0110111};
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] ins, input logic [4:0] xrd,
                        input logic [31:0] xres, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd);
      instr_valid = iv;
      instr       = ins;
      ex_rd       = xrd;
      ex_result   = xres;
      wb_en       = we;
      wb_rd       = wrd;
      wb_data     = wd;
   endtask

   task automatic exp_out(input string t, input logic [4:0] er, input logic [31:0] ea, eb,
                          input logic [5:0] es, input logic [2:0] ef, input logic ei, ev, el);
      chk({t, ".rdi"}, 32'(rdi), 32'(er));
      chk({t, ".a"}, a, ea);
      chk({t, ".b"}, b, eb);
      chk({t, ".shamt"}, 32'(shamt), 32'(es));
      chk({t, ".funct3"}, 32'(funct3), 32'(ef));
      chk({t, ".invertb"}, 32'(invertb), 32'(ei));
      chk({t, ".valid"}, 32'(valid), 32'(ev));
      chk({t, ".illegal"}, 32'(illegal), 32'(el));
   endtask

   // called at a negedge: check ready before the edge, outputs just after it, return to negedge
   task automatic step(input vec_t v, input string t);
      drive(v.iv, v.instr, v.exrd, v.exres, v.wbe, v.wbrd, v.wbd);
      #1 chk({t, ".ready"}, 32'(instr_ready), 32'(v.rdy));
      @(posedge clk);
      #1 exp_out(t, v.rdi, v.a, v.b, v.sh, v.f3, v.inv, v.val, v.ill);
      @(negedge clk);
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("idle%0d.ready", i), 32'(instr_ready), 32'd1);
         edge_wait();
         exp_out($sformatf("idle%0d", i), 5'd0, 32'h0, 32'h0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 32'd40);
      @(negedge clk);
      drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 32'd2);
      @(negedge clk);
      drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hFFFFFFF0);
      @(negedge clk);

      tv[0]  = '{1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), 0, 0, 0, 0, 0, 1, 4, 40, 2, 0, 0, 0, 1, 0};
      tv[1]  = '{1, enc_i(12'hFFB, 5'd0, 3'd0, 5'd5), 0, 0, 0, 0, 0, 1, 5, 0, 32'hFFFFFFFB, 0, 0, 0, 1, 0};
      tv[2]  = '{1, enc_i(12'h403, 5'd1, 3'd5, 5'd6), 0, 0, 0, 0, 0, 1, 6, 40, 32'h403, 3, 5, 1, 1, 0};
      tv[3]  = '{1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7), 0, 0, 0, 0, 0, 1, 7, 40, 2, 0, 0, 1, 1, 0};
      tv[4]  = '{1, enc_r(7'h00, 5'd2, 5'd3, 3'd1, 5'd8), 0, 0, 0, 0, 0, 1, 8, 32'hFFFFFFF0, 2, 2, 1, 0, 1, 0};
      tv[5]  = '{1, enc_r(7'h20, 5'd1, 5'd3, 3'd5, 5'd9), 0, 0, 0, 0, 0, 1, 9, 32'hFFFFFFF0, 40, 8, 5, 1, 1, 0};
      tv[6]  = '{1, enc_u(20'h12345, 5'd10), 0, 0, 0, 0, 0, 1, 10, 0, 32'h12345000, 0, 0, 0, 1, 0};
      tv[7]  = '{1, 32'h0000007F, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      tv[8]  = '{1, enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd4), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      tv[9]  = '{1, enc_r(7'h20, 5'd2, 5'd1, 3'd4, 5'd4), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      tv[10] = '{1, enc_i(12'h021, 5'd1, 3'd1, 5'd3), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      tv[11] = '{1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd11), 1, 99, 0, 0, 0, 1, 11, 99, 2, 0, 0, 0, 1, 0};
      tv[12] = '{1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd12), 0, 0, 1, 2, 7, 1, 12, 40, 7, 0, 0, 0, 1, 0};
      tv[13] = '{1, enc_r(7'h00, 5'd0, 5'd2, 3'd6, 5'd13), 2, 5, 1, 2, 8, 1, 13, 5, 0, 0, 6, 0, 1, 0};
      tv[14] = '{0, enc_r(7'h00, 5'd13, 5'd13, 3'd0, 5'd1), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      tv[15] = '{1, enc_i(12'hFFF, 5'd2, 3'd7, 5'd14), 0, 0, 0, 0, 0, 1, 14, 8, 32'hFFFFFFFF, 0, 7, 0, 1, 0};
      tv[16] = '{0, 32'h0, 0, 0, 1, 0, 123, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      tv[17] = '{1, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd15), 0, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 1, 0};
      tv[18] = '{1, enc_u(20'h00078, 5'd16), 0, 0, 0, 0, 0, 1, 16, 0, 32'h00078000, 0, 0, 0, 1, 0};
      for (int i = 0; i < 19; i++) step(tv[i], $sformatf("v%0d", i));

      // RAW hazard on rs1 then on rs2, each resolved by the ex forward path
      drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 32'd2);
      edge_wait();
      @(negedge clk);
      drive(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      edge_wait();
      exp_out("h_add", 5'd4, 32'd40, 32'd2, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, enc_r(7'h20, 5'd2, 5'd4, 3'd0, 5'd7), 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1 chk("h_sub_stall.ready", 32'(instr_ready), 32'd0);
      edge_wait();
      exp_out("h_bubble", 5'd0, 32'h0, 32'h0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ex_rd = 5'd4;
      ex_result = 32'd42;
      #1 chk("h_sub_go.ready", 32'(instr_ready), 32'd1);
      edge_wait();
      exp_out("h_sub", 5'd7, 32'd42, 32'd2, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, enc_r(7'h00, 5'd7, 5'd2, 3'd4, 5'd8), 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1 chk("h_xor_stall.ready", 32'(instr_ready), 32'd0);
      edge_wait();
      exp_out("h_bubble2", 5'd0, 32'h0, 32'h0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      ex_rd = 5'd7;
      ex_result = 32'd3;
      #1 chk("h_xor_go.ready", 32'(instr_ready), 32'd1);
      edge_wait();
      exp_out("h_xor", 5'd8, 32'd2, 32'd3, 6'd0, 3'd4, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      // reset during a stall, with a coincident writeback that must be dropped
      drive(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      edge_wait();
      @(negedge clk);
      drive(1'b1, enc_r(7'h20, 5'd2, 5'd4, 3'd0, 5'd7), 5'd0, 32'h0, 1'b1, 5'd1, 32'd77);
      rst = 1'b1;
      #1 chk("r_stall.ready", 32'(instr_ready), 32'd0);
      edge_wait();
      exp_out("r_after", 5'd0, 32'h0, 32'h0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk("r_after.ready", 32'(instr_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd20), 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      edge_wait();
      exp_out("r_clr12", 5'd20, 32'h0, 32'h0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b1, enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd21), 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      edge_wait();
      exp_out("r_clr3", 5'd21, 32'h0, 32'h0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      instr_valid = 1'b0;
      edge_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
